// File: rtl/cmd_proc.sv
// Command processor: decodes remote commands and sequences calibration, heading,
// forward-speed ramps and maze-solve hand-off, answering 0xA5 on completion.
module cmd_proc #(
  parameter bit          FAST_SIM  = 1'b1,
  parameter logic [10:0] MAX_FRWRD = 11'h2A0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic [7:0]  resp,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic        in_cal,
  output logic [11:0] dsrd_hdg,
  input  logic        hdg_settled,
  input  logic        hdg_rdy,
  output logic [10:0] frwrd,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  output logic        strt_slv,
  output logic        slv_lft,
  input  logic        sol_cmplt,
  output logic        cmd_md
);

  localparam logic [10:0] STEP    = FAST_SIM ? 11'h020 : 11'h002;
  localparam logic [11:0] DN_STEP = {STEP, 1'b0};

  typedef enum logic [2:0] {
    IDLE, CAL, HDG, RAMP_UP, CRUISE, RAMP_DN, SOLVE, ACK
  } state_t;

  state_t      state;
  logic        stop_lft, stop_rght;
  logic        lft_q, rght_q;
  logic        hdg_wait;
  logic        stop_move;
  logic [11:0] frwrd_inc;
  logic [10:0] frwrd_up, frwrd_dn;
  logic        unused_cmd;

  assign resp       = 8'hA5;
  assign unused_cmd = cmd[12];

  assign frwrd_inc = {1'b0, frwrd} + {1'b0, STEP};
  assign frwrd_up  = (frwrd_inc >= {1'b0, MAX_FRWRD}) ? MAX_FRWRD : frwrd_inc[10:0];
  assign frwrd_dn  = ({1'b0, frwrd} > DN_STEP) ? (frwrd - DN_STEP[10:0]) : 11'd0;

  // Only a fresh opening (low-to-high) stops a move; a side already open is ignored.
  assign stop_move = ~frwrd_opn
                   | (stop_lft  & lft_opn  & ~lft_q)
                   | (stop_rght & rght_opn & ~rght_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= 1'b0;
      rght_q <= 1'b0;
    end else begin
      lft_q  <= lft_opn;
      rght_q <= rght_opn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frwrd       <= '0;
      dsrd_hdg    <= '0;
      cmd_md      <= 1'b1;
      in_cal      <= 1'b0;
      slv_lft     <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      strt_cal    <= 1'b0;
      strt_slv    <= 1'b0;
      stop_lft    <= 1'b0;
      stop_rght   <= 1'b0;
      hdg_wait    <= 1'b0;
    end else begin
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      strt_cal    <= 1'b0;
      strt_slv    <= 1'b0;
      case (state)
        // cmd_rdy seen while clr_cmd_rdy is still out is the command just consumed
        IDLE: begin
          if (cmd_rdy && !clr_cmd_rdy) begin
            clr_cmd_rdy <= 1'b1;
            case (cmd[15:13])
              3'b000: begin
                strt_cal <= 1'b1;
                in_cal   <= 1'b1;
                state    <= CAL;
              end
              3'b001: begin
                dsrd_hdg <= cmd[11:0];
                hdg_wait <= 1'b1;
                state    <= HDG;
              end
              3'b010: begin
                stop_lft  <= cmd[1];
                stop_rght <= cmd[0];
                frwrd     <= '0;
                state     <= RAMP_UP;
              end
              3'b011: begin
                slv_lft  <= cmd[0];
                strt_slv <= 1'b1;
                cmd_md   <= 1'b0;
                state    <= SOLVE;
              end
              default: state <= IDLE;
            endcase
          end
        end
        CAL: begin
          if (cal_done) begin
            in_cal    <= 1'b0;
            send_resp <= 1'b1;
            state     <= ACK;
          end
        end
        // the PID needs a clock to see the new heading before settled means anything
        HDG: begin
          if (hdg_wait) begin
            hdg_wait <= 1'b0;
          end else if (hdg_settled) begin
            send_resp <= 1'b1;
            state     <= ACK;
          end
        end
        RAMP_UP: begin
          if (stop_move) begin
            state <= RAMP_DN;
          end else if (hdg_rdy) begin
            frwrd <= frwrd_up;
            if (frwrd_up == MAX_FRWRD) state <= CRUISE;
          end
        end
        CRUISE: begin
          if (stop_move) state <= RAMP_DN;
        end
        RAMP_DN: begin
          if (frwrd == '0) begin
            send_resp <= 1'b1;
            state     <= ACK;
          end else if (hdg_rdy) begin
            frwrd <= frwrd_dn;
          end
        end
        // strt_slv marks the first solve cycle; maze_solve cannot be done yet
        SOLVE: begin
          if (sol_cmplt && !strt_slv) begin
            cmd_md    <= 1'b1;
            frwrd     <= '0;
            send_resp <= 1'b1;
            state     <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
